add_nnbit_ahead_pipe: RTL and testbench
=======================================

Name: add_nnbit_ahead_pipe

Overview:
- Pipelined, parametrised carry-lookahead adder/subtractor; next generation of the combinational N-bit lookahead adder.
- Splits the DATA_WIDTH operands into STAGE_NUM slices. Each slice is summed by a lookahead slice adder in its own pipeline stage, and the slice carry is registered into the next stage.
- Adds valid/ready handshaking with backpressure, a subtract mode, and signed overflow.
- Sits between operand producers (ALU, address generators) and consumers that need high clock rate at wide widths.

Parameters:
- DATA_WIDTH, 32, operand/result width; must be a multiple of STAGE_NUM.
- STAGE_NUM, 4, pipeline stages = slices; 1..DATA_WIDTH. Slice width SW = DATA_WIDTH/STAGE_NUM.
- GROUP_WIDTH, 4, lookahead group width inside each slice adder; must divide SW, else clamp to SW.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  synchronous reset, active-high.
- i_valid  input  1  operand set valid.
- o_ready  output  1  block can accept operands this cycle.
- i_num_a  input  DATA_WIDTH  operand A.
- i_num_b  input  DATA_WIDTH  operand B.
- i_cry  input  1  carry-in (add) / borrow-in (sub).
- i_sub  input  1  0: add, 1: subtract.
- o_valid  output  1  result valid.
- i_ready  input  1  consumer accepts result.
- o_res  output  DATA_WIDTH  result.
- o_cry  output  1  carry-out; in sub mode 1 = no borrow.
- o_ovf  output  1  signed two's-complement overflow.

Behaviour:
- Reset: one clock and a single synchronous active-high reset i_rst; no asynchronous paths.
  - While i_rst=1 at a rising edge, all stage valid bits clear and o_valid/o_res/o_cry/o_ovf are 0 the next cycle.
  - o_ready=1 once reset is released.
  - Reset mid-operation discards all in-flight operations; no partial result is emitted.
- Arithmetic:
  - i_sub=0: {o_cry,o_res} = A + B + i_cry.
  - i_sub=1: {o_cry,o_res} = A + ~B + ~i_cry, i.e. A − B − i_cry modulo 2^DATA_WIDTH.
  - o_ovf = carry into MSB XOR carry out of MSB, using the effective B.
- Pipeline enable en = ~o_valid | i_ready. o_ready = en (combinational).
  - When en=1, every stage shifts forward one position.
  - When en=0, all stages hold, including bubbles; bubbles are not collapsed.
- Transfers:
  - Input transfer when i_valid & o_ready.
  - Output transfer when o_valid & i_ready.
  - A cycle with both a transfer in and a transfer out is legal.
  - i_valid=0 with en=1 inserts a bubble.
- Stage k (0..STAGE_NUM−1):
  - Adds slice k (bits [k*SW +: SW]) of A and the effective B.
  - Carry-in is the registered carry from stage k−1. For stage 0 it is the effective carry-in (i_cry, or ~i_cry when subtracting).
  - Operand slices above k travel in skew registers.
  - Completed lower result slices travel in deskew registers, so the final stage registers all outputs aligned.
- Latency: operand accepted at edge t gives o_valid=1 after edge t+STAGE_NUM−1, registered, when no stall occurs. Throughput is 1 op/cycle.
- i_sub travels with its operand set; mixed add/sub back-to-back are independent.
- Results leave in acceptance order.
- o_res/o_cry/o_ovf hold stable while o_valid=1 and i_ready=0.
- STAGE_NUM=1: a single registered lookahead adder with the same handshake.

Optional Feature:
- Macro ADD_NNBIT_PIPE_FLAG_EN.
- Defined: adds output ports o_zero (o_res==0) and o_neg (o_res MSB), 1 bit each, registered with the result, aligned with o_valid, reset to 0.
- Undefined: these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Add chain (DATA_WIDTH=8, STAGE_NUM=2, i_ready=1), one op per cycle, all results 2 cycles after acceptance, in order:
  - 0xF0+0xF0+0 → 0xE0, cry=1, ovf=0.
  - 0xFF+0xFF+0 → 0xFE, cry=1.
  - 0xF5+0xF5+1 → 0xEB, cry=1.
- Overflow and subtract:
  - 0x7F+0x01+0 → 0x80, ovf=1, cry=0.
  - sub 0x05−0x07, cry=0 → 0xFE, cry=0 (borrow), ovf=0.
  - sub 0x80−0x01 → 0x7F, ovf=1, cry=1.
- Backpressure: 4 back-to-back ops with i_ready=0 for 3 cycles once o_valid rises.
  - o_ready drops in the first stall cycle; o_res stays stable.
  - No op is lost or duplicated; order is preserved after i_ready=1.
- Bubbles: i_valid pattern 1,0,1 produces o_valid pattern 1,0,1 shifted by latency.
- Reset mid-flight: two ops in flight, assert i_rst one cycle.
  - o_valid=0 and o_res=0 next cycle; neither op appears later.
- Width sweep: DATA_WIDTH=32 with STAGE_NUM 1, 4, 8 and random A/B/cry/sub.
  - Every result matches the reference model; latency equals STAGE_NUM.
  - With ADD_NNBIT_PIPE_FLAG_EN, 0x00000001+0xFFFFFFFF+0 → o_zero=1, o_cry=1.

Source files
------------

// File: rtl/add_nnbit_ahead_pipe.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// The operands are cut into STAGE_NUM slices; slice k is summed in pipeline
// stage k and its carry is registered into stage k+1. Unprocessed operand
// slices ride along in skew registers, finished result slices in deskew
// registers, so the last stage presents the whole result aligned.
// Optional feature: define ADD_NNBIT_PIPE_FLAG_EN to add the registered
// o_zero / o_neg result flags.
module add_nnbit_ahead_pipe #(
   parameter int DATA_WIDTH  = 32,
   parameter int STAGE_NUM   = 4,
   parameter int GROUP_WIDTH = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [DATA_WIDTH-1:0] i_num_a,
   input  logic [DATA_WIDTH-1:0] i_num_b,
   input  logic                  i_cry,
   input  logic                  i_sub,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [DATA_WIDTH-1:0] o_res,
   output logic                  o_cry,
   output logic                  o_ovf
`ifdef ADD_NNBIT_PIPE_FLAG_EN
   ,
   output logic                  o_zero,
   output logic                  o_neg
`endif
);

   localparam int DW     = DATA_WIDTH;
   localparam int SN     = STAGE_NUM;
   localparam int SW     = DW / SN;
   localparam int GW_REQ = (GROUP_WIDTH < 1) ? 1 : GROUP_WIDTH;
   // a group width that does not tile the slice degrades to one group per slice
   localparam int GW     = (GW_REQ <= SW && (SW % GW_REQ) == 0) ? GW_REQ : SW;

   // Slice adder: bit-level g/p, lookahead carries inside each group, group
   // carries chained across the slice. Returns {carry out, carry into MSB, sum}.
   function automatic logic [SW+1:0] cla_slice(input logic [SW-1:0] a,
                                                input logic [SW-1:0] b,
                                                input logic          cin);
      logic [SW-1:0] g;
      logic [SW-1:0] p;
      logic [SW:0]   c;
      logic          gg;
      logic          gp;
      g    = a & b;
      p    = a ^ b;
      c    = '0;
      c[0] = cin;
      for (int grp = 0; grp < SW / GW; grp++) begin
         gg = 1'b0;
         gp = 1'b1;
         for (int j = 0; j < GW; j++) begin
            c[grp*GW + j] = gg | (gp & c[grp*GW]);
            gg = g[grp*GW + j] | (p[grp*GW + j] & gg);
            gp = gp & p[grp*GW + j];
         end
         c[grp*GW + GW] = gg | (gp & c[grp*GW]);
      end
      return {c[SW], c[SW-1], p ^ c[SW-1:0]};
   endfunction

   // ra_q[k]: result slices 0..k below, still-unprocessed A slices above
   logic [DW-1:0] ra_q   [SN];
   logic [DW-1:0] b_q    [SN];
   logic          cry_q  [SN];
   logic [SN-1:0] vld;
   logic          ovf_q;

   logic [DW-1:0] ra_in  [SN];
   logic [DW-1:0] b_in   [SN];
   logic          c_in   [SN];
   logic [DW-1:0] ra_nxt [SN];
   logic          c_nxt  [SN];
   logic          ovf_nxt;
   logic [SW+1:0] sl;
   logic          en;

   // whole pipeline advances together; a stalled output freezes bubbles too
   assign en      = ~vld[SN-1] | i_ready;
   assign o_ready = en;
   assign o_valid = vld[SN-1];
   assign o_res   = ra_q[SN-1];
   assign o_cry   = cry_q[SN-1];
   assign o_ovf   = ovf_q;

   // per-stage slice addition; subtract folds into inverted B and carry at entry
   always_comb begin
      sl       = '0;
      ovf_nxt  = 1'b0;
      ra_in[0] = i_num_a;
      b_in[0]  = i_sub ? ~i_num_b : i_num_b;
      c_in[0]  = i_cry ^ i_sub;
      for (int k = 1; k < SN; k++) begin
         ra_in[k] = ra_q[k-1];
         b_in[k]  = b_q[k-1];
         c_in[k]  = cry_q[k-1];
      end
      for (int k = 0; k < SN; k++) begin
         sl                     = cla_slice(ra_in[k][k*SW +: SW], b_in[k][k*SW +: SW], c_in[k]);
         ra_nxt[k]              = ra_in[k];
         ra_nxt[k][k*SW +: SW]  = sl[SW-1:0];
         c_nxt[k]               = sl[SW+1];
         if (k == SN - 1) begin
            ovf_nxt = sl[SW+1] ^ sl[SW];
         end
      end
   end

   // stage registers: valid chain, skew/deskew data, slice carries, overflow
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         vld   <= '0;
         ovf_q <= 1'b0;
         for (int k = 0; k < SN; k++) begin
            ra_q[k]  <= '0;
            b_q[k]   <= '0;
            cry_q[k] <= 1'b0;
         end
      end else if (en) begin
         vld[0] <= i_valid;
         for (int k = 1; k < SN; k++) begin
            vld[k] <= vld[k-1];
         end
         for (int k = 0; k < SN; k++) begin
            ra_q[k]  <= ra_nxt[k];
            b_q[k]   <= b_in[k];
            cry_q[k] <= c_nxt[k];
         end
         ovf_q <= ovf_nxt;
      end
   end

`ifdef ADD_NNBIT_PIPE_FLAG_EN
   logic zero_q;
   logic neg_q;

   // result flags registered alongside the final result slice
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         zero_q <= 1'b0;
         neg_q  <= 1'b0;
      end else if (en) begin
         zero_q <= ~|ra_nxt[SN-1];
         neg_q  <= ra_nxt[SN-1][DW-1];
      end
   end

   assign o_zero = zero_q;
   assign o_neg  = neg_q;
`endif

endmodule

// File: tb/tb_add_nnbit_ahead_pipe.sv
// Bench for add_nnbit_ahead_pipe: an 8-bit/2-stage instance driven with
// directed vectors (chains, overflow, subtract, bubbles, backpressure, reset
// mid-flight) and three 32-bit instances (1, 4, 8 stages) fed a shared mix of
// fixed and random operands checked against a reference model.
module tb_add_nnbit_ahead_pipe;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int n_out8   = 0;
   bit lat_chk8 = 1'b1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // 8-bit, 2-stage instance
   logic       v8, ordy8, ov8, rdy_in8, c8, s8, cry8, ovf8;
   logic [7:0] a8, b8, res8;
`ifdef ADD_NNBIT_PIPE_FLAG_EN
   logic       zero8, neg8;
`endif

   add_nnbit_ahead_pipe #(.DATA_WIDTH(8), .STAGE_NUM(2), .GROUP_WIDTH(4)) u_dut8 (
      .i_clk(clk), .i_rst(rst), .i_valid(v8), .o_ready(ordy8),
      .i_num_a(a8), .i_num_b(b8), .i_cry(c8), .i_sub(s8),
      .o_valid(ov8), .i_ready(rdy_in8), .o_res(res8), .o_cry(cry8), .o_ovf(ovf8)
`ifdef ADD_NNBIT_PIPE_FLAG_EN
      , .o_zero(zero8), .o_neg(neg8)
`endif
   );

   // 32-bit instances sharing one input stream, consumer always ready
   logic        v32, c32, s32;
   logic [31:0] a32, b32;
   logic        rdy32 = 1'b1;
   logic        ov32 [3];
   logic        ordy32 [3];
   logic [31:0] res32 [3];
   logic        cry32 [3];
   logic        ovf32 [3];
`ifdef ADD_NNBIT_PIPE_FLAG_EN
   logic        zero32 [3];
   logic        neg32 [3];
`endif
   localparam int STG32 [3] = '{1, 4, 8};

   add_nnbit_ahead_pipe #(.DATA_WIDTH(32), .STAGE_NUM(1), .GROUP_WIDTH(4)) u_dut32_s1 (
      .i_clk(clk), .i_rst(rst), .i_valid(v32), .o_ready(ordy32[0]),
      .i_num_a(a32), .i_num_b(b32), .i_cry(c32), .i_sub(s32),
      .o_valid(ov32[0]), .i_ready(rdy32), .o_res(res32[0]), .o_cry(cry32[0]), .o_ovf(ovf32[0])
`ifdef ADD_NNBIT_PIPE_FLAG_EN
      , .o_zero(zero32[0]), .o_neg(neg32[0])
`endif
   );

   add_nnbit_ahead_pipe #(.DATA_WIDTH(32), .STAGE_NUM(4), .GROUP_WIDTH(4)) u_dut32_s4 (
      .i_clk(clk), .i_rst(rst), .i_valid(v32), .o_ready(ordy32[1]),
      .i_num_a(a32), .i_num_b(b32), .i_cry(c32), .i_sub(s32),
      .o_valid(ov32[1]), .i_ready(rdy32), .o_res(res32[1]), .o_cry(cry32[1]), .o_ovf(ovf32[1])
`ifdef ADD_NNBIT_PIPE_FLAG_EN
      , .o_zero(zero32[1]), .o_neg(neg32[1])
`endif
   );

   // group width 3 does not tile a 4-bit slice and must fall back to 4
   add_nnbit_ahead_pipe #(.DATA_WIDTH(32), .STAGE_NUM(8), .GROUP_WIDTH(3)) u_dut32_s8 (
      .i_clk(clk), .i_rst(rst), .i_valid(v32), .o_ready(ordy32[2]),
      .i_num_a(a32), .i_num_b(b32), .i_cry(c32), .i_sub(s32),
      .o_valid(ov32[2]), .i_ready(rdy32), .o_res(res32[2]), .o_cry(cry32[2]), .o_ovf(ovf32[2])
`ifdef ADD_NNBIT_PIPE_FLAG_EN
      , .o_zero(zero32[2]), .o_neg(neg32[2])
`endif
   );

   // expected results {ovf, cry, res} with the acceptance edge number
   logic [9:0]  q8 [$];
   int          t8 [$];
   logic [33:0] q32 [3][$];
   int          t32 [3][$];

   function automatic logic [33:0] model32(input logic [31:0] a, input logic [31:0] b,
                                           input logic c, input logic s);
      logic [31:0] be;
      logic        ce;
      logic [32:0] sum;
      logic        ovf;
      be  = s ? ~b : b;
      ce  = s ? ~c : c;
      sum = {1'b0, a} + {1'b0, be} + {32'd0, ce};
      ovf = (a[31] == be[31]) && (sum[31] != a[31]);
      return {ovf, sum[32], sum[31:0]};
   endfunction

   // present one operand set on the 8-bit instance, wait until it is taken
   task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s,
                        input logic [7:0] er, input logic ec, input logic eo);
      int n;
      n  = 0;
      a8 = a; b8 = b; c8 = c; s8 = s; v8 = 1'b1;
      #3;
      while (!ordy8 && n < 20) begin
         @(negedge clk);
         #3;
         n++;
      end
      chk("u8_accept", ordy8, 1'b1);
      q8.push_back({eo, ec, er});
      t8.push_back(cyc + 1);
      @(negedge clk);
   endtask

   // 8-bit output monitor, sampled just before the transfer edge
   always @(negedge clk) begin
      logic [9:0] e;
      int         t;
      #3;
      if (!rst && ov8 && rdy_in8) begin
         n_out8++;
         chk("u8_pending", q8.size() > 0, 1'b1);
         if (q8.size() > 0) begin
            e = q8.pop_front();
            t = t8.pop_front();
            chk("u8_out", {ovf8, cry8, res8}, e);
`ifdef ADD_NNBIT_PIPE_FLAG_EN
            chk("u8_zero", zero8, e[7:0] == 8'd0);
            chk("u8_neg", neg8, e[7]);
`endif
            if (lat_chk8) chk("u8_lat", cyc - t, 1);
         end
      end
   end

   // 32-bit output monitor
   always @(negedge clk) begin
      logic [33:0] e;
      int          t;
      #3;
      if (!rst) begin
         for (int j = 0; j < 3; j++) begin
            if (ov32[j]) begin
               chk($sformatf("u32_s%0d_pending", STG32[j]), q32[j].size() > 0, 1'b1);
               if (q32[j].size() > 0) begin
                  e = q32[j].pop_front();
                  t = t32[j].pop_front();
                  chk($sformatf("u32_s%0d_out", STG32[j]), {ovf32[j], cry32[j], res32[j]}, e);
                  chk($sformatf("u32_s%0d_lat", STG32[j]), cyc - t, STG32[j] - 1);
`ifdef ADD_NNBIT_PIPE_FLAG_EN
                  chk($sformatf("u32_s%0d_zero", STG32[j]), zero32[j], e[31:0] == 32'd0);
                  chk($sformatf("u32_s%0d_neg", STG32[j]), neg32[j], e[31]);
`endif
               end
            end
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] e_hold;
      int         n0;
      rst = 1'b1;
      v8 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0; s8 = 1'b0; rdy_in8 = 1'b1;
      v32 = 1'b0; a32 = '0; b32 = '0; c32 = 1'b0; s32 = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst_valid8", ov8, 1'b0);
      chk("rst_res8", {ovf8, cry8, res8}, 10'd0);
`ifdef ADD_NNBIT_PIPE_FLAG_EN
      chk("rst_flags8", {zero8, neg8}, 2'b00);
`endif
      for (int j = 0; j < 3; j++) begin
         chk("rst_valid32", ov32[j], 1'b0);
         chk("rst_res32", {ovf32[j], cry32[j], res32[j]}, 34'd0);
      end
      rst = 1'b0;
      #1 chk("rdy_after_rst", ordy8, 1'b1);
      @(negedge clk);

      // add chain, overflow and subtract, one per cycle
      send8(8'hF0, 8'hF0, 1'b0, 1'b0, 8'hE0, 1'b1, 1'b0);
      send8(8'hFF, 8'hFF, 1'b0, 1'b0, 8'hFE, 1'b1, 1'b0);
      send8(8'hF5, 8'hF5, 1'b1, 1'b0, 8'hEB, 1'b1, 1'b0);
      send8(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
      send8(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
      send8(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
      send8(8'h10, 8'h01, 1'b1, 1'b1, 8'h0E, 1'b1, 1'b0);
      v8 = 1'b0;
      repeat (4) @(negedge clk);
      chk("chain_drain", q8.size(), 0);

      // bubble: valid pattern 1,0,1
      send8(8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0);
      v8 = 1'b0;
      @(negedge clk);
      #1 chk("bubble_first", ov8, 1'b1);
      send8(8'h55, 8'h2A, 1'b0, 1'b1, 8'h2B, 1'b1, 1'b0);
      v8 = 1'b0;
      #1 chk("bubble_gap", ov8, 1'b0);
      @(negedge clk);
      #1 chk("bubble_second", ov8, 1'b1);
      repeat (3) @(negedge clk);

      // backpressure: 4 back-to-back ops, consumer stalls 3 cycles
      lat_chk8 = 1'b0;
      n0 = n_out8;
      fork
         begin
            send8(8'h11, 8'h22, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0);
            send8(8'h40, 8'h40, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
            send8(8'hC0, 8'h40, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
            send8(8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
            v8 = 1'b0;
         end
         begin
            int n;
            n = 0;
            @(negedge clk);
            while (!ov8 && n < 20) begin
               @(negedge clk);
               n++;
            end
            #2 rdy_in8 = 1'b0;
            #1;
            chk("bp_ready_drop", ordy8, 1'b0);
            e_hold = q8[0];
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               #2;
               if (i == 2) rdy_in8 = 1'b1;
               #1;
               chk("bp_hold", {ovf8, cry8, res8}, e_hold);
               chk("bp_valid", ov8, 1'b1);
            end
         end
      join
      repeat (8) @(negedge clk);
      chk("bp_drain", q8.size(), 0);
      chk("bp_count", n_out8 - n0, 4);
      lat_chk8 = 1'b1;

      // reset with two ops in flight, output held by the consumer
      rdy_in8 = 1'b0;
      send8(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);
      send8(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0);
      v8  = 1'b0;
      rst = 1'b1;
      q8.delete();
      t8.delete();
      @(negedge clk);
      #1;
      chk("midrst_valid", ov8, 1'b0);
      chk("midrst_res", {ovf8, cry8, res8}, 10'd0);
      rst     = 1'b0;
      rdy_in8 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1 chk("midrst_nothing", ov8, 1'b0);
      end

      // 32-bit sweep: fixed corner vectors among random ones, random bubbles
      @(negedge clk);
      for (int i = 0; i < 48; i++) begin
         if (i == 5) begin
            a32 = 32'h8000_0000; b32 = 32'h0000_0001; c32 = 1'b0; s32 = 1'b1; v32 = 1'b1;
         end else if (i == 20) begin
            a32 = 32'h0000_0001; b32 = 32'hFFFF_FFFF; c32 = 1'b0; s32 = 1'b0; v32 = 1'b1;
         end else if (i == 30) begin
            a32 = 32'h0000_0000; b32 = 32'h0000_0000; c32 = 1'b1; s32 = 1'b1; v32 = 1'b1;
         end else begin
            a32 = $urandom; b32 = $urandom;
            c32 = 1'($urandom_range(0, 1)); s32 = 1'($urandom_range(0, 1));
            v32 = ($urandom_range(0, 3) != 0);
         end
         if (v32) begin
            for (int j = 0; j < 3; j++) begin
               q32[j].push_back(model32(a32, b32, c32, s32));
               t32[j].push_back(cyc + 1);
            end
         end
         @(negedge clk);
      end
      v32 = 1'b0;
      repeat (12) @(negedge clk);
      for (int j = 0; j < 3; j++) begin
         chk($sformatf("u32_s%0d_drain", STG32[j]), q32[j].size(), 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
